// File: rtl/imu_frame_parser.sv
// Byte-stream parser for 11-byte IMU frames (header 0x55, types 0x51..0x53) with
// checksum verification, resync timeout, gyro moving average and motion/still flags.
module imu_frame_parser #(
  parameter int          AVG_LOG2    = 3,
  parameter int          AVG_CH      = 2,
  parameter logic [15:0] THR_MOTION  = 16'h6000,
  parameter logic [15:0] THR_STILL   = 16'h0600,
  parameter int          TIMEOUT_CYC = 25000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic [15:0] acc_x,
  output logic [15:0] acc_y,
  output logic [15:0] acc_z,
  output logic [15:0] gyr_x,
  output logic [15:0] gyr_y,
  output logic [15:0] gyr_z,
  output logic [15:0] ang_x,
  output logic [15:0] ang_y,
  output logic [15:0] ang_z,
  output logic [15:0] temp,
  output logic        acc_vld,
  output logic        gyr_vld,
  output logic        ang_vld,
  output logic        chk_err,
  output logic        sync_lost,
  output logic [7:0]  err_cnt,
  output logic [15:0] gyr_avg,
  output logic        motion_flag,
  output logic        still_flag
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = 16 + AVG_LOG2;
  localparam int IW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_HUNT, S_TYPE, S_PAYLOAD, S_CHECK} state_t;

  state_t                state, state_next;
  logic [7:0]            sum;
  logic [1:0]            ftype;
  logic [2:0]            byte_cnt;
  logic [7:0]            shadow [8];
  logic [IW-1:0]         idle_cnt;
  logic                  is_type, timeout_hit, frame_good, frame_bad;

  logic signed [15:0]    ring [DEPTH];
  logic [AVG_LOG2-1:0]   wr_ptr;
  logic signed [SW-1:0]  avg_sum, new_sum;
  logic [15:0]           sample, new_avg;

  // |v| with the single unrepresentable value -32768 clamped to 32767
  function automatic logic [15:0] abs_sat(input logic [15:0] v);
    if (v == 16'h8000) return 16'h7FFF;
    else if (v[15])    return -v;
    else               return v;
  endfunction

  assign is_type = (rx_byte == 8'h51) || (rx_byte == 8'h52) || (rx_byte == 8'h53);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_HUNT;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    timeout_hit = 1'b0;
    frame_good  = 1'b0;
    frame_bad   = 1'b0;
    if (state != S_HUNT && !rx_valid && idle_cnt == IDLE_LAST) begin
      timeout_hit = 1'b1;
      state_next  = S_HUNT;
    end else if (rx_valid) begin
      case (state)
        S_HUNT:    if (rx_byte == 8'h55) state_next = S_TYPE;
        S_TYPE:    if (is_type) state_next = S_PAYLOAD;
                   else if (rx_byte != 8'h55) state_next = S_HUNT;
        S_PAYLOAD: if (byte_cnt == 3'd7) state_next = S_CHECK;
        default: begin
          state_next = S_HUNT;
          frame_good = (rx_byte == sum);
          frame_bad  = (rx_byte != sum);
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0; ftype <= '0; byte_cnt <= '0; idle_cnt <= '0;
      for (int i = 0; i < 8; i++) shadow[i] <= '0;
      acc_x <= '0; acc_y <= '0; acc_z <= '0;
      gyr_x <= '0; gyr_y <= '0; gyr_z <= '0;
      ang_x <= '0; ang_y <= '0; ang_z <= '0;
      temp <= '0; err_cnt <= '0;
      acc_vld <= 1'b0; gyr_vld <= 1'b0; ang_vld <= 1'b0;
      chk_err <= 1'b0; sync_lost <= 1'b0;
    end else begin
      acc_vld   <= 1'b0;
      gyr_vld   <= 1'b0;
      ang_vld   <= 1'b0;
      chk_err   <= frame_bad;
      sync_lost <= timeout_hit;
      if (state == S_HUNT || rx_valid || timeout_hit) idle_cnt <= '0;
      else                                            idle_cnt <= idle_cnt + 1'b1;
      if ((frame_bad || timeout_hit) && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      if (rx_valid) begin
        case (state)
          S_HUNT: if (rx_byte == 8'h55) sum <= 8'h55;
          S_TYPE: begin
            if (rx_byte == 8'h55) sum <= 8'h55;
            else if (is_type) begin
              ftype    <= rx_byte[1:0];
              sum      <= sum + rx_byte;
              byte_cnt <= '0;
            end
          end
          S_PAYLOAD: begin
            shadow[byte_cnt] <= rx_byte;
            sum              <= sum + rx_byte;
            byte_cnt         <= byte_cnt + 1'b1;
          end
          default: ;
        endcase
      end
      // Checksum matched: publish the shadow buffer to the frame type's outputs
      if (frame_good) begin
        temp <= {shadow[7], shadow[6]};
        case (ftype)
          2'd1: begin
            acc_x <= {shadow[1], shadow[0]}; acc_y <= {shadow[3], shadow[2]};
            acc_z <= {shadow[5], shadow[4]}; acc_vld <= 1'b1;
          end
          2'd2: begin
            gyr_x <= {shadow[1], shadow[0]}; gyr_y <= {shadow[3], shadow[2]};
            gyr_z <= {shadow[5], shadow[4]}; gyr_vld <= 1'b1;
          end
          default: begin
            ang_x <= {shadow[1], shadow[0]}; ang_y <= {shadow[3], shadow[2]};
            ang_z <= {shadow[5], shadow[4]}; ang_vld <= 1'b1;
          end
        endcase
      end
    end
  end

  always_comb begin
    case (AVG_CH)
      0:       sample = gyr_x;
      1:       sample = gyr_y;
      default: sample = gyr_z;
    endcase
  end

  // Running sum replaces the oldest entry; dropping the low bits is a floor division
  assign new_sum = avg_sum + {{AVG_LOG2{sample[15]}}, sample}
                           - {{AVG_LOG2{ring[wr_ptr][15]}}, ring[wr_ptr]};
  assign new_avg = new_sum[AVG_LOG2 +: 16];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
      wr_ptr      <= '0;
      avg_sum     <= '0;
      gyr_avg     <= '0;
      motion_flag <= 1'b0;
      still_flag  <= 1'b0;
    end else if (gyr_vld) begin
      ring[wr_ptr] <= sample;
      wr_ptr       <= wr_ptr + 1'b1;
      avg_sum      <= new_sum;
      gyr_avg      <= new_avg;
      motion_flag  <= (abs_sat(new_avg) >= THR_MOTION);
      still_flag   <= (abs_sat(sample) <= THR_STILL);
    end
  end

endmodule

// File: tb/tb_imu_frame_parser.sv
// Self-checking bench for imu_frame_parser: directed frames plus randomized traffic
// compared against a queue-based reference model of the frame and averaging rules.
module tb_imu_frame_parser;

  localparam int          AVG_LOG2    = 3;
  localparam int          AVG_CH      = 2;
  localparam logic [15:0] THR_MOTION  = 16'h6000;
  localparam logic [15:0] THR_STILL   = 16'h0600;
  localparam int          TIMEOUT_CYC = 25000;

  logic        clk, rst_n, rx_valid;
  logic [7:0]  rx_byte;
  logic [15:0] acc_x, acc_y, acc_z, gyr_x, gyr_y, gyr_z, ang_x, ang_y, ang_z, temp, gyr_avg;
  logic        acc_vld, gyr_vld, ang_vld, chk_err, sync_lost, motion_flag, still_flag;
  logic [7:0]  err_cnt;

  imu_frame_parser #(
    .AVG_LOG2(AVG_LOG2), .AVG_CH(AVG_CH), .THR_MOTION(THR_MOTION),
    .THR_STILL(THR_STILL), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .acc_x(acc_x), .acc_y(acc_y), .acc_z(acc_z),
    .gyr_x(gyr_x), .gyr_y(gyr_y), .gyr_z(gyr_z),
    .ang_x(ang_x), .ang_y(ang_y), .ang_z(ang_z),
    .temp(temp), .acc_vld(acc_vld), .gyr_vld(gyr_vld), .ang_vld(ang_vld),
    .chk_err(chk_err), .sync_lost(sync_lost), .err_cnt(err_cnt),
    .gyr_avg(gyr_avg), .motion_flag(motion_flag), .still_flag(still_flag)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int seen_acc = 0, seen_gyr = 0, seen_ang = 0, seen_chk = 0, seen_sync = 0;
  int want_acc = 0, want_gyr = 0, want_ang = 0, want_chk = 0, want_sync = 0;

  logic [15:0] m_acc [3], m_gyr [3], m_ang [3];
  logic [15:0] m_temp, m_avg;
  int          m_err;
  bit          m_motion, m_still;
  int          m_window [$];

  // Pulse widths: every cycle a strobe is high counts once
  always @(negedge clk) begin
    if (rst_n) begin
      if (acc_vld)   seen_acc++;
      if (gyr_vld)   seen_gyr++;
      if (ang_vld)   seen_ang++;
      if (chk_err)   seen_chk++;
      if (sync_lost) seen_sync++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int absSat(input int v);
    if (v < -32767) return 32767;
    return (v < 0) ? -v : v;
  endfunction

  function automatic int floorDiv(input int a, input int d);
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 3; i++) begin
      m_acc[i] = '0; m_gyr[i] = '0; m_ang[i] = '0;
    end
    m_temp = '0; m_avg = '0; m_err = 0; m_motion = 0; m_still = 0;
    m_window = {};
    for (int i = 0; i < (1 << AVG_LOG2); i++) m_window.push_back(0);
  endtask

  task automatic modelGyro(input logic [15:0] w);
    logic signed [15:0] ws;
    int s, total, avg;
    ws = w;
    s = ws;
    m_window.push_back(s);
    void'(m_window.pop_front());
    total = 0;
    foreach (m_window[i]) total += m_window[i];
    avg      = floorDiv(total, 1 << AVG_LOG2);
    m_avg    = avg[15:0];
    m_motion = (absSat(avg) >= int'(THR_MOTION));
    m_still  = (absSat(s) <= int'(THR_STILL));
  endtask

  task automatic checkFields();
    checkOutput("acc_x", acc_x, m_acc[0]); checkOutput("acc_y", acc_y, m_acc[1]);
    checkOutput("acc_z", acc_z, m_acc[2]);
    checkOutput("gyr_x", gyr_x, m_gyr[0]); checkOutput("gyr_y", gyr_y, m_gyr[1]);
    checkOutput("gyr_z", gyr_z, m_gyr[2]);
    checkOutput("ang_x", ang_x, m_ang[0]); checkOutput("ang_y", ang_y, m_ang[1]);
    checkOutput("ang_z", ang_z, m_ang[2]);
    checkOutput("temp", temp, m_temp);
    checkOutput("err_cnt", err_cnt, m_err);
  endtask

  task automatic checkAvg();
    checkOutput("gyr_avg", gyr_avg, m_avg);
    checkOutput("motion_flag", motion_flag, m_motion);
    checkOutput("still_flag", still_flag, m_still);
  endtask

  task automatic checkQuiet();
    checkOutput("strobes_idle", {acc_vld, gyr_vld, ang_vld, chk_err, sync_lost}, 5'b0);
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic applyStimulus(input logic [7:0] ftype, input logic [15:0] w0, w1, w2, t,
                               input bit bad, input int gap);
    logic [7:0]  frame [11];
    logic [7:0]  s;
    logic [15:0] sel;
    frame = '{8'h55, ftype, w0[7:0], w0[15:8], w1[7:0], w1[15:8],
              w2[7:0], w2[15:8], t[7:0], t[15:8], 8'h00};
    s = '0;
    for (int i = 0; i < 10; i++) s = s + frame[i];
    frame[10] = bad ? s + 8'd1 : s;
    for (int i = 0; i < 11; i++) sendByte(frame[i], (i == 10) ? 0 : gap);
    if (bad) begin
      want_chk++;
      if (m_err < 255) m_err++;
    end else begin
      m_temp = t;
      case (ftype)
        8'h51:   begin m_acc = '{w0, w1, w2}; want_acc++; end
        8'h52:   begin m_gyr = '{w0, w1, w2}; want_gyr++; end
        default: begin m_ang = '{w0, w1, w2}; want_ang++; end
      endcase
    end
    checkOutput("acc_vld", acc_vld, !bad && ftype == 8'h51);
    checkOutput("gyr_vld", gyr_vld, !bad && ftype == 8'h52);
    checkOutput("ang_vld", ang_vld, !bad && ftype == 8'h53);
    checkOutput("chk_err", chk_err, bad);
    checkFields();
    @(posedge clk); #1;
    sel = (AVG_CH == 0) ? w0 : (AVG_CH == 1) ? w1 : w2;
    if (!bad && ftype == 8'h52) modelGyro(sel);
    checkQuiet();
    checkAvg();
  endtask

  task automatic pulseReset();
    rst_n = 1'b0;
    #1;
    modelReset();
    checkFields();
    checkAvg();
    checkQuiet();
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int cyc;
    logic [7:0]  ty, g;
    logic [15:0] r0, r1, r2;
    rst_n = 1'b0; rx_valid = 1'b0; rx_byte = '0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkFields(); checkAvg(); checkQuiet();
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] checksum error then good gyro frame");
    applyStimulus(8'h52, 16'h0010, 16'h0020, 16'h0030, 16'h0000, 1'b1, 0);
    checkOutput("bad_err_cnt", err_cnt, 8'd1);
    checkOutput("bad_gyr_x", gyr_x, 16'h0000);
    applyStimulus(8'h52, 16'h0010, 16'h0020, 16'h0030, 16'h0000, 1'b0, 0);
    checkOutput("good_gyr_x", gyr_x, 16'h0010);
    checkOutput("good_gyr_z", gyr_z, 16'h0030);
    checkOutput("good_acc_x", acc_x, 16'h0000);

    $display("[TB] resync through garbage and repeated header");
    sendByte(8'h00, 0); sendByte(8'hAA, 0); sendByte(8'h55, 0);
    applyStimulus(8'h52, 16'h1234, 16'hFEDC, 16'h0400, 16'h0BEE, 1'b0, 1);

    $display("[TB] mid-frame stall");
    sendByte(8'h55, 0); sendByte(8'h52, 0); sendByte(8'h10, 0); sendByte(8'h00, 0);
    cyc = 0;
    while (!sync_lost && cyc < TIMEOUT_CYC + 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("sync_lost_latency", (cyc >= TIMEOUT_CYC - 1 && cyc <= TIMEOUT_CYC + 1), 1'b1);
    want_sync++;
    m_err++;
    @(posedge clk); #1;
    checkOutput("timeout_err_cnt", err_cnt, m_err);
    checkQuiet();
    applyStimulus(8'h53, 16'h0101, 16'h0202, 16'h0303, 16'h0044, 1'b0, 0);

    $display("[TB] reset in the middle of a frame");
    for (int i = 0; i < 5; i++) sendByte((i == 0) ? 8'h55 : (i == 1) ? 8'h52 : 8'h33, 0);
    pulseReset();

    $display("[TB] moving average of gyr_z");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(8'h52, 16'($urandom), 16'($urandom), 16'h7000, 16'h0100, 1'b0, 0);
      if (i == 0) begin
        checkOutput("avg_first", gyr_avg, 16'h0E00);
        checkOutput("motion_first", motion_flag, 1'b0);
      end
    end
    checkOutput("avg_full", gyr_avg, 16'h7000);
    checkOutput("motion_full", motion_flag, 1'b1);
    applyStimulus(8'h52, 16'h0000, 16'h0000, 16'h0100, 16'h0100, 1'b0, 0);
    checkOutput("still_small", still_flag, 1'b1);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        g = 8'($urandom);
        if (g == 8'h55) g = 8'h00;
        sendByte(g, $urandom_range(0, 2));
      end
      ty = 8'h51 + 8'($urandom_range(0, 2));
      r0 = 16'($urandom);
      r1 = 16'($urandom);
      r2 = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 16'h0800)) - 16'h0400
                                       : 16'($urandom);
      if ($urandom_range(0, 9) == 0) r2 = 16'h8000;
      applyStimulus(ty, r0, r1, r2, 16'($urandom), $urandom_range(0, 4) == 0,
                    $urandom_range(0, 2));
    end

    $display("[TB] error counter saturation");
    for (int n = 0; n < 260; n++)
      applyStimulus(8'h51, 16'($urandom), 16'($urandom), 16'($urandom), 16'h0000, 1'b1, 0);
    checkOutput("err_cnt_sat", err_cnt, 8'hFF);

    @(posedge clk); #1;
    checkOutput("acc_pulses", seen_acc, want_acc);
    checkOutput("gyr_pulses", seen_gyr, want_gyr);
    checkOutput("ang_pulses", seen_ang, want_ang);
    checkOutput("chk_pulses", seen_chk, want_chk);
    checkOutput("sync_pulses", seen_sync, want_sync);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
